// File: rtl/lnrv_icb_mux_if.sv
// ----------------------------------------------------------------------------
// lnrv_icb_mux_if
// ICB bus bundle carrying P_COUNT command/response channels side by side.
// Channel i occupies bit i of every 1-bit-per-channel signal and slice i of
// every packed payload (cmd_addr, cmd_wdata, cmd_wstrb, rsp_rdata).
//
// Handshake rule (both channels): a transfer happens in the cycle where
// valid and ready are both 1 at the rising clock edge. Once raised, valid
// and its payload hold until that transfer; ready may change freely.
//
// Signals:
//   cmd_vld / cmd_rdy      command valid / ready
//   cmd_write              1 = write, 0 = read
//   cmd_addr / cmd_wdata   command address / write data
//   cmd_wstrb              write byte strobes
//   rsp_vld / rsp_rdy      response valid / ready
//   rsp_rdata / rsp_err    response read data / error flag
//
// Modports:
//   master  drives commands, accepts responses
//   slave   accepts commands, drives responses
// ----------------------------------------------------------------------------
interface lnrv_icb_mux_if #(
    parameter int P_ADDR_WIDTH = 32,
    parameter int P_DATA_WIDTH = 32,
    parameter int P_COUNT      = 1
);
    logic [P_COUNT-1:0]                    cmd_vld;
    logic [P_COUNT-1:0]                    cmd_rdy;
    logic [P_COUNT-1:0]                    cmd_write;
    logic [P_ADDR_WIDTH*P_COUNT-1:0]       cmd_addr;
    logic [P_DATA_WIDTH*P_COUNT-1:0]       cmd_wdata;
    logic [(P_DATA_WIDTH/8)*P_COUNT-1:0]   cmd_wstrb;
    logic [P_COUNT-1:0]                    rsp_vld;
    logic [P_COUNT-1:0]                    rsp_rdy;
    logic [P_DATA_WIDTH*P_COUNT-1:0]       rsp_rdata;
    logic [P_COUNT-1:0]                    rsp_err;

    modport master (
        output cmd_vld, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_rdy,
        input  cmd_rdy, rsp_vld, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_vld, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_rdy,
        output cmd_rdy, rsp_vld, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lnrv_icb_mux.sv
// ----------------------------------------------------------------------------
// lnrv_icb_mux
// N-to-1 ICB multiplexer. Upstream masters compete for a single downstream
// slave port. The command path is purely combinational (grant, valid and
// payload reach s_icb in the same cycle). Each accepted command records its
// issuing master in an order FIFO so responses, which return in command order,
// are steered back to the right master.
//
// Arbitration: round-robin starting after the last granted master. Defining
// LNRV_ICB_MUX_FIXED_PRIO_EN selects fixed priority (lowest index wins) and
// removes the round-robin pointer. In both builds a command that is offered
// but not accepted locks the grant until it completes, keeping the payload
// seen by the slave stable.
//
// Ports:
//   clk             clock, all state on rising edge
//   reset           asynchronous, active-high reset
//   mn_icb          upstream bundle, P_ICB_COUNT channels (slave modport)
//   s_icb           downstream bundle, one channel (master modport)
//   dbg_arb_state   arbiter state: 0 = OPEN, 1 = LOCK
// ----------------------------------------------------------------------------
module lnrv_icb_mux #(
    parameter int P_ADDR_WIDTH = 32,
    parameter int P_DATA_WIDTH = 32,
    parameter int P_ICB_COUNT  = 4,
    parameter int P_OTS_COUNT  = 2
) (
    input  logic           clk,
    input  logic           reset,
    lnrv_icb_mux_if.slave  mn_icb,
    lnrv_icb_mux_if.master s_icb,
    output logic           dbg_arb_state
);
    localparam int N  = P_ICB_COUNT;
    localparam int A  = P_ADDR_WIDTH;
    localparam int D  = P_DATA_WIDTH;
    localparam int S  = P_DATA_WIDTH / 8;
    localparam int IW = $clog2(N);
    localparam int OW = (P_OTS_COUNT > 1) ? $clog2(P_OTS_COUNT) : 1;
    localparam int CW = $clog2(P_OTS_COUNT + 1);

    typedef enum logic {
        ST_OPEN = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    arb_state_t    state_q, state_d;
    logic [IW-1:0] lock_idx_q;
    logic [IW-1:0] pick_idx;
    logic          pick_vld;
    logic [IW-1:0] grant_idx;
    logic          grant_vld;

    logic          s_cmd_vld;
    logic          s_rsp_rdy;
    logic          cmd_hs;
    logic          rsp_hs;

    logic [OW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [IW-1:0] order_mem [P_OTS_COUNT];
    logic [IW-1:0] head_idx;
    logic          ots_full, ots_empty;

    function automatic logic [OW-1:0] ptr_inc(input logic [OW-1:0] p);
        return (p == OW'(P_OTS_COUNT - 1)) ? '0 : p + OW'(1);
    endfunction

    // ------------------------------------------------------------------
    // Candidate winner among current requesters
    // ------------------------------------------------------------------
`ifdef LNRV_ICB_MUX_FIXED_PRIO_EN
    // Scan downwards so the lowest requesting index is the last to write.
    always_comb begin
        pick_idx = '0;
        pick_vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mn_icb.cmd_vld[i]) begin
                pick_idx = IW'(i);
                pick_vld = 1'b1;
            end
        end
    end
`else
    logic [IW-1:0] rr_ptr_q;
    int            rr_idx;

    // Offsets scanned from farthest to nearest so the first requester after
    // rr_ptr (nearest offset) overrides any later one.
    always_comb begin
        pick_idx = '0;
        pick_vld = 1'b0;
        rr_idx   = 0;
        for (int k = N; k >= 1; k--) begin
            rr_idx = (int'(rr_ptr_q) + k) % N;
            if (mn_icb.cmd_vld[rr_idx]) begin
                pick_idx = IW'(rr_idx);
                pick_vld = 1'b1;
            end
        end
    end

    // Reset value N-1 makes master 0 the first winner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= IW'(N - 1);
        end else if (cmd_hs) begin
            rr_ptr_q <= grant_idx;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Arbiter FSM: OPEN recomputes the grant every cycle, LOCK holds it
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_OPEN;
            lock_idx_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_OPEN && state_d == ST_LOCK) begin
                lock_idx_q <= grant_idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_idx = pick_idx;
        grant_vld = pick_vld;
        case (state_q)
            ST_OPEN: begin
                if (s_cmd_vld && !s_icb.cmd_rdy) begin
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                grant_idx = lock_idx_q;
                grant_vld = 1'b1;
                if (cmd_hs) begin
                    state_d = ST_OPEN;
                end
            end
            default: state_d = ST_OPEN;
        endcase
    end

    assign dbg_arb_state = (state_q == ST_LOCK);

    // ------------------------------------------------------------------
    // Command path (combinational)
    // ------------------------------------------------------------------
    // A full order FIFO blocks new commands; it is a registered count, so a
    // response popping in the same cycle frees a slot only from the next one.
    assign s_cmd_vld = grant_vld && mn_icb.cmd_vld[grant_idx] && !ots_full && !reset;
    assign cmd_hs    = s_cmd_vld && s_icb.cmd_rdy;

    assign s_icb.cmd_vld   = s_cmd_vld;
    assign s_icb.cmd_write = mn_icb.cmd_write[grant_idx];
    assign s_icb.cmd_addr  = mn_icb.cmd_addr[grant_idx*A +: A];
    assign s_icb.cmd_wdata = mn_icb.cmd_wdata[grant_idx*D +: D];
    assign s_icb.cmd_wstrb = mn_icb.cmd_wstrb[grant_idx*S +: S];

    always_comb begin
        mn_icb.cmd_rdy = '0;
        if (grant_vld && s_icb.cmd_rdy && !ots_full && !reset) begin
            mn_icb.cmd_rdy[grant_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Order FIFO: issuing master of every outstanding command
    // ------------------------------------------------------------------
    assign ots_full  = (count_q == CW'(P_OTS_COUNT));
    assign ots_empty = (count_q == '0);
    assign head_idx  = order_mem[rd_ptr_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (cmd_hs) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (rsp_hs) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (cmd_hs && !rsp_hs) begin
                count_q <= count_q + CW'(1);
            end else if (!cmd_hs && rsp_hs) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Entries are only read while the count marks them live, so no reset.
    always_ff @(posedge clk) begin
        if (cmd_hs) begin
            order_mem[wr_ptr_q] <= grant_idx;
        end
    end

    // ------------------------------------------------------------------
    // Response path: steer to the FIFO head; nothing passes while empty
    // ------------------------------------------------------------------
    assign s_rsp_rdy       = !ots_empty && !reset && mn_icb.rsp_rdy[head_idx];
    assign rsp_hs          = s_rsp_rdy && s_icb.rsp_vld;
    assign s_icb.rsp_rdy   = s_rsp_rdy;
    assign mn_icb.rsp_rdata = {N{s_icb.rsp_rdata}};
    assign mn_icb.rsp_err   = {N{s_icb.rsp_err}};

    always_comb begin
        mn_icb.rsp_vld = '0;
        if (!ots_empty && !reset && s_icb.rsp_vld) begin
            mn_icb.rsp_vld[head_idx] = 1'b1;
        end
    end
endmodule

// File: tb/tb_lnrv_icb_mux.sv
`timescale 1ns/1ps
module tb_lnrv_icb_mux;
    localparam int N   = 4;
    localparam int A   = 32;
    localparam int D   = 32;
    localparam int S   = 4;
    localparam int OTS = 2;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Stimulus signals and DUT
    // ------------------------------------------------------------------
    logic [N-1:0] m_vld, m_write, m_rsp_rdy;
    logic [A-1:0] m_addr  [N];
    logic [D-1:0] m_wdata [N];
    logic [S-1:0] m_wstrb [N];
    logic         s_cmd_rdy, s_rsp_vld, s_rsp_err;
    logic [D-1:0] s_rsp_rdata;
    logic         dbg_arb_state;

    lnrv_icb_mux_if #(.P_ADDR_WIDTH(A), .P_DATA_WIDTH(D), .P_COUNT(N)) mn_icb ();
    lnrv_icb_mux_if #(.P_ADDR_WIDTH(A), .P_DATA_WIDTH(D), .P_COUNT(1)) s_icb ();

    assign mn_icb.cmd_vld   = m_vld;
    assign mn_icb.cmd_write = m_write;
    assign mn_icb.rsp_rdy   = m_rsp_rdy;
    always_comb begin
        for (int i = 0; i < N; i++) begin
            mn_icb.cmd_addr[i*A +: A]  = m_addr[i];
            mn_icb.cmd_wdata[i*D +: D] = m_wdata[i];
            mn_icb.cmd_wstrb[i*S +: S] = m_wstrb[i];
        end
    end
    assign s_icb.cmd_rdy   = s_cmd_rdy;
    assign s_icb.rsp_vld   = s_rsp_vld;
    assign s_icb.rsp_rdata = s_rsp_rdata;
    assign s_icb.rsp_err   = s_rsp_err;

    lnrv_icb_mux #(
        .P_ADDR_WIDTH(A), .P_DATA_WIDTH(D), .P_ICB_COUNT(N), .P_OTS_COUNT(OTS)
    ) dut (
        .clk(clk), .reset(reset), .mn_icb(mn_icb), .s_icb(s_icb),
        .dbg_arb_state(dbg_arb_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard state and check helper
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;
    int ots_q[$];      // issuers of outstanding commands, oldest first
    int grant_log[$];  // master of every accepted command
    int rsp_log[$];    // master of every delivered response
    int rr_m;
    bit locked_m;
    int lock_m;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] req, input int rr);
`ifdef LNRV_ICB_MUX_FIXED_PRIO_EN
        if (rr >= N) return -1;
        for (int i = 0; i < N; i++) if (req[i]) return i;
`else
        for (int k = 1; k <= N; k++) if (req[(rr + k) % N]) return (rr + k) % N;
`endif
        return -1;
    endfunction

    // ------------------------------------------------------------------
    // Compare process: expectations at negedge, model update at posedge
    // ------------------------------------------------------------------
    initial begin
        int g, head;
        bit full, empty, exp_s_vld, cmd_hs, rsp_hs;
        logic [N-1:0] exp_cmd_rdy, exp_rsp_vld;
        logic exp_s_rsp_rdy;
        forever begin
            @(negedge clk);
            cmd_hs = 0;
            rsp_hs = 0;
            g = -1;
            head = 0;
            if (reset) begin
                ots_q.delete();
                rr_m = N - 1;
                locked_m = 0;
                lock_m = 0;
                check("rst_s_cmd_vld", s_icb.cmd_vld, 0);
                check("rst_s_rsp_rdy", s_icb.rsp_rdy, 0);
                check("rst_mn_cmd_rdy", mn_icb.cmd_rdy, 0);
                check("rst_mn_rsp_vld", mn_icb.rsp_vld, 0);
            end else begin
                full  = (ots_q.size() == OTS);
                empty = (ots_q.size() == 0);
                g = locked_m ? lock_m : model_pick(m_vld, rr_m);
                exp_s_vld = 0;
                exp_cmd_rdy = '0;
                if (g >= 0) begin
                    exp_s_vld = m_vld[g] && !full;
                    if (s_cmd_rdy && !full) exp_cmd_rdy[g] = 1'b1;
                end
                check("s_cmd_vld", s_icb.cmd_vld, exp_s_vld);
                check("mn_cmd_rdy", mn_icb.cmd_rdy, exp_cmd_rdy);
                check("arb_lock", dbg_arb_state, locked_m);
                if (exp_s_vld) begin
                    check("s_cmd_addr", s_icb.cmd_addr, m_addr[g]);
                    check("s_cmd_wdata", s_icb.cmd_wdata, m_wdata[g]);
                    check("s_cmd_wstrb", s_icb.cmd_wstrb, m_wstrb[g]);
                    check("s_cmd_write", s_icb.cmd_write, m_write[g]);
                end
                exp_rsp_vld = '0;
                exp_s_rsp_rdy = 1'b0;
                if (!empty) begin
                    head = ots_q[0];
                    if (s_rsp_vld) exp_rsp_vld[head] = 1'b1;
                    exp_s_rsp_rdy = m_rsp_rdy[head];
                end
                check("mn_rsp_vld", mn_icb.rsp_vld, exp_rsp_vld);
                check("s_rsp_rdy", s_icb.rsp_rdy, exp_s_rsp_rdy);
                if (exp_rsp_vld != 0) begin
                    for (int i = 0; i < N; i++) begin
                        check("mn_rsp_rdata", mn_icb.rsp_rdata[i*D +: D], s_rsp_rdata);
                        check("mn_rsp_err", mn_icb.rsp_err[i], s_rsp_err);
                    end
                end
                cmd_hs = exp_s_vld && s_cmd_rdy;
                rsp_hs = !empty && s_rsp_vld && m_rsp_rdy[head];
            end
            @(posedge clk);
            if (!reset) begin
                if (rsp_hs) begin
                    rsp_log.push_back(head);
                    void'(ots_q.pop_front());
                end
                if (cmd_hs) begin
                    ots_q.push_back(g);
                    grant_log.push_back(g);
                    rr_m = g;
                    locked_m = 0;
                end else if (!locked_m && exp_s_vld) begin
                    locked_m = 1;
                    lock_m = g;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Directed sequences with literal expectations
    // ------------------------------------------------------------------
    initial begin
`ifdef LNRV_ICB_MUX_FIXED_PRIO_EN
        int exp_order[6] = '{0, 0, 0, 0, 0, 0};
`else
        int exp_order[6] = '{0, 1, 2, 0, 1, 2};
`endif
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            m_addr[i]  = 32'h1000_0000 + 32'(i) * 32'h100;
            m_wdata[i] = 32'hD000_0000 + 32'(i);
            m_wstrb[i] = S'(1 << i);
        end
        m_write     = 4'b0101;
        m_rsp_rdy   = '1;
        m_vld       = '1;
        s_cmd_rdy   = 1'b1;
        s_rsp_vld   = 1'b1;
        s_rsp_rdata = '0;
        s_rsp_err   = 1'b0;
        step(3);
        check("reset_s_cmd_vld", s_icb.cmd_vld, 0);
        check("reset_mn_cmd_rdy", mn_icb.cmd_rdy, 0);
        m_vld = '0;
        s_rsp_vld = 1'b0;
        reset = 1'b0;

        // Three masters request continuously, slave answers the next cycle.
        grant_log.delete();
        rsp_log.delete();
        m_vld = 4'b0111;
        s_rsp_vld = 1'b1;
        s_rsp_rdata = 32'h5A5A_0000;
        #1;
        check("first_grant", mn_icb.cmd_rdy, 4'b0001);
        step(6);
        m_vld = '0;
        step(1);
        s_rsp_vld = 1'b0;
        check("order_len", grant_log.size(), 6);
        check("rsp_len", rsp_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < grant_log.size()) check("grant_order", grant_log[i], exp_order[i]);
            if (i < rsp_log.size()) check("rsp_issuer", rsp_log[i], exp_order[i]);
        end

        // Slave stalls master 1; master 0 joins but the grant is locked.
        s_cmd_rdy = 1'b0;
        m_vld = 4'b0010;
        #1;
        check("lock_c1_vld", s_icb.cmd_vld, 1);
        check("lock_c1_addr", s_icb.cmd_addr, 32'h1000_0100);
        step(1);
        m_vld = 4'b0011;
        #1;
        check("lock_c2_addr", s_icb.cmd_addr, 32'h1000_0100);
        check("lock_c2_state", dbg_arb_state, 1);
        step(1);
        check("lock_c3_addr", s_icb.cmd_addr, 32'h1000_0100);
        step(1);
        s_cmd_rdy = 1'b1;
        #1;
        check("lock_c4_rdy", mn_icb.cmd_rdy, 4'b0010);
        step(1);
        m_vld = '0;
        check("lock_winner", grant_log[$], 1);
        s_rsp_vld = 1'b1;
        step(1);
        s_rsp_vld = 1'b0;
        check("lock_rsp", rsp_log[$], 1);

        // Order FIFO full: third command waits until a response drains.
        m_vld = 4'b0001;
        step(1);
        m_vld = 4'b0010;
        step(1);
        m_vld = 4'b0100;
        #1;
        check("full_s_vld", s_icb.cmd_vld, 0);
        check("full_rdy", mn_icb.cmd_rdy, 0);
        step(1);
        s_rsp_vld = 1'b1;
        #1;
        check("full_pop_rsp_vld", mn_icb.rsp_vld, 4'b0001);
        check("full_pop_rdy", mn_icb.cmd_rdy, 0);
        step(1);
        s_rsp_vld = 1'b0;
        #1;
        check("full_release_rdy", mn_icb.cmd_rdy, 4'b0100);
        step(1);
        m_vld = '0;
        s_rsp_vld = 1'b1;
        step(2);
        s_rsp_vld = 1'b0;
        check("full_rsp_a", rsp_log[$-1], 1);
        check("full_rsp_b", rsp_log[$], 2);

        // Responses for masters 3 then 0, with one cycle of master 3 backpressure.
        m_vld = 4'b1000;
        step(1);
        m_vld = 4'b0001;
        step(1);
        m_vld = '0;
        s_rsp_vld = 1'b1;
        s_rsp_rdata = 32'hAAAA_0003;
        s_rsp_err = 1'b0;
        m_rsp_rdy = 4'b0111;
        #1;
        check("bp_s_rsp_rdy", s_icb.rsp_rdy, 0);
        check("bp_rsp_vld", mn_icb.rsp_vld, 4'b1000);
        step(1);
        m_rsp_rdy = '1;
        #1;
        check("r3_vld", mn_icb.rsp_vld, 4'b1000);
        check("r3_rdata", mn_icb.rsp_rdata[3*D +: D], 32'hAAAA_0003);
        check("r3_err", mn_icb.rsp_err[3], 0);
        step(1);
        s_rsp_rdata = 32'h0000_0000;
        s_rsp_err = 1'b1;
        #1;
        check("r0_vld", mn_icb.rsp_vld, 4'b0001);
        check("r0_err", mn_icb.rsp_err[0], 1);
        step(1);
        s_rsp_vld = 1'b0;
        s_rsp_err = 1'b0;
        check("r_order_a", rsp_log[$-1], 3);
        check("r_order_b", rsp_log[$], 0);

        // Reset with two outstanding commands.
        m_vld = 4'b0010;
        step(1);
        m_vld = 4'b0100;
        step(1);
        m_vld = 4'b1111;
        s_rsp_vld = 1'b1;
        #1;
        check("pre_rst_rsp_vld", mn_icb.rsp_vld, 4'b0010);
        reset = 1'b1;
        #1;
        check("arst_s_cmd_vld", s_icb.cmd_vld, 0);
        check("arst_s_rsp_rdy", s_icb.rsp_rdy, 0);
        check("arst_mn_cmd_rdy", mn_icb.cmd_rdy, 0);
        check("arst_mn_rsp_vld", mn_icb.rsp_vld, 0);
        step(2);
        reset = 1'b0;
        m_vld = '0;
        #1;
        check("stray_s_rsp_rdy", s_icb.rsp_rdy, 0);
        check("stray_rsp_vld", mn_icb.rsp_vld, 0);
        step(1);
        s_rsp_vld = 1'b0;
        m_vld = 4'b0101;
        #1;
        check("post_rst_grant", mn_icb.cmd_rdy, 4'b0001);
        check("post_rst_addr", s_icb.cmd_addr, 32'h1000_0000);
        step(1);
        m_vld = '0;
        s_rsp_vld = 1'b1;
        step(1);
        s_rsp_vld = 1'b0;
        check("post_rst_rsp", rsp_log[$], 0);

`ifdef LNRV_ICB_MUX_FIXED_PRIO_EN
        // Fixed priority: master 0 always beats master 2.
        m_vld = 4'b0101;
        s_rsp_vld = 1'b1;
        step(5);
        m_vld = '0;
        step(1);
        s_rsp_vld = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            check("fixed_prio_grant", grant_log[grant_log.size() - i], 0);
        end
`endif

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
